// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Holds the state encoding, the opcode/funct and ALU codes, and the per-state control decode.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // fetch/jump/branch are the pre-gating sources of irwrite and pcen
   typedef struct packed {
      logic       fetch;
      logic       jump;
      logic       branch;
      logic       memwrite;
      logic       iord;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      aluop_t     aluop;
   } ctrl_t;

   function automatic logic op_legal(logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

   function automatic ctrl_t decode_ctrl(state_t s);
      ctrl_t c;
      c       = '0;
      c.aluop = ALUOP_ADD;
      case (s)
         S_FETCH:   begin c.fetch = 1'b1; c.alusrcb = 2'b01; end
         S_DECODE:  c.alusrcb = 2'b11;
         S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_MEMRD:   c.iord = 1'b1;
         S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
         S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         S_BEQEX:   begin
            c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1;
         end
         S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_ADDIWB:  c.regwrite = 1'b1;
         S_JEX:     begin c.pcsrc = 2'b10; c.jump = 1'b1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
interface mc_controller_if #(parameter int CNT_W = 16);
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             memwrite;
   logic             irwrite;
   logic             iord;
   logic             regwrite;
   logic             regdst;
   logic             memtoreg;
   logic             alusrca;
   logic [1:0]       alusrcb;
   logic [1:0]       pcsrc;
   logic             pcen;
   logic [2:0]       alucont;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  op, funct, zero, mem_ready,
      output memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, pcen, alucont, illegal, retired
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, pcen, alucont, illegal, retired
   );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU control decode: FSM aluop plus instruction funct field to the alucont code.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucont
);
   always_comb begin
      alucont = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucont = ALU_ADD;
         ALUOP_SUB: alucont = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucont = ALU_ADD;
               FN_SUB:  alucont = ALU_SUB;
               FN_AND:  alucont = ALU_AND;
               FN_OR:   alucont = ALU_OR;
               FN_SLT:  alucont = ALU_SLT;
               default: alucont = ALU_ADD;
            endcase
         end
         default: alucont = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath enable and counts retired instructions.
module mc_controller
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int CNT_W    = 16
) (
   input logic             clk,
   input logic             reset_n,
   mc_controller_if.master bus
);
   state_t           state, nxt;
   ctrl_t            ctrl;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   logic             mem_rdy;

   assign mem_rdy = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

   always_comb begin
      nxt    = state;
      retire = 1'b0;
      case (state)
         S_FETCH:   if (mem_rdy) nxt = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE:     nxt = S_RTYPEEX;
               OP_BEQ:       nxt = S_BEQEX;
               OP_ADDI:      nxt = S_ADDIEX;
               OP_J:         nxt = S_JEX;
               default:      nxt = S_FETCH;
            endcase
         end
         S_MEMADR:  nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_rdy) nxt = S_MEMWB;
         S_MEMWB:   begin nxt = S_FETCH; retire = 1'b1; end
         S_MEMWR:   if (mem_rdy) begin nxt = S_FETCH; retire = 1'b1; end
         S_RTYPEEX: nxt = S_RTYPEWB;
         S_RTYPEWB: begin nxt = S_FETCH; retire = 1'b1; end
         S_BEQEX:   begin nxt = S_FETCH; retire = 1'b1; end
         S_ADDIEX:  nxt = S_ADDIWB;
         S_ADDIWB:  begin nxt = S_FETCH; retire = 1'b1; end
         S_JEX:     begin nxt = S_FETCH; retire = 1'b1; end
         default:   nxt = S_FETCH;
      endcase
   end

   // Control word is registered from the next state, so it is already a Moore decode of `state`
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_FETCH;
         ctrl      <= decode_ctrl(S_FETCH);
         retired_q <= '0;
      end else begin
         state <= nxt;
         ctrl  <= decode_ctrl(nxt);
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   alu_decoder u_alu_decoder (
      .aluop   (ctrl.aluop),
      .funct   (bus.funct),
      .alucont (bus.alucont)
   );

   // FETCH is the reset state, so its mem_ready-gated enables also need reset_n gating
   assign bus.irwrite  = reset_n & ctrl.fetch & mem_rdy;
   assign bus.pcen     = reset_n & ((ctrl.fetch & mem_rdy) | ctrl.jump | (ctrl.branch & bus.zero));
   assign bus.memwrite = ctrl.memwrite;
   assign bus.iord     = ctrl.iord;
   assign bus.regwrite = ctrl.regwrite;
   assign bus.regdst   = ctrl.regdst;
   assign bus.memtoreg = ctrl.memtoreg;
   assign bus.alusrca  = ctrl.alusrca;
   assign bus.alusrcb  = ctrl.alusrcb;
   assign bus.pcsrc    = ctrl.pcsrc;
   assign bus.illegal  = (state == S_DECODE) && !op_legal(bus.op);
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a cycle-level instruction model queues expected
// outputs; a monitor compares a 16-bit-counter instance and a 2-bit-counter instance.
module tb_mc_controller;
   typedef struct packed {
      logic       memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic       pcen;
      logic [2:0] alucont;
      logic       illegal;
      logic [15:0] retired;
   } rec_t;

   typedef struct {
      string nm;
      rec_t  r;
      bit    chk_alu;
   } item_t;

   logic        clk;
   logic        reset_n;
   item_t       q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned exp_ret = 0;

   mc_controller_if #(.CNT_W(16)) bus1();
   mc_controller_if #(.CNT_W(2))  bus2();

   assign bus2.op        = bus1.op;
   assign bus2.funct     = bus1.funct;
   assign bus2.zero      = bus1.zero;
   assign bus2.mem_ready = bus1.mem_ready;

   mc_controller #(.MEM_WAIT(1), .CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus1));
   mc_controller #(.MEM_WAIT(1), .CNT_W(2))  dut_w2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic rec_t sample1();
      return {bus1.memwrite, bus1.irwrite, bus1.iord, bus1.regwrite, bus1.regdst,
              bus1.memtoreg, bus1.alusrca, bus1.alusrcb, bus1.pcsrc, bus1.pcen,
              bus1.alucont, bus1.illegal, bus1.retired};
   endfunction

   function automatic rec_t sample2();
      return {bus2.memwrite, bus2.irwrite, bus2.iord, bus2.regwrite, bus2.regdst,
              bus2.memtoreg, bus2.alusrca, bus2.alusrcb, bus2.pcsrc, bus2.pcen,
              bus2.alucont, bus2.illegal, 14'd0, bus2.retired};
   endfunction

   task automatic check(string nm, rec_t act, rec_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t act=%h exp=%h (act retired=%0d exp retired=%0d)",
                  nm, $time, act, exp, act.retired, exp.retired);
      end
   endtask

   // monitor: one expected record per cycle, compared mid-cycle on the falling edge
   initial begin
      item_t it;
      rec_t  a1, a2, e2;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            it = q.pop_front();
            a1 = sample1();
            a2 = sample2();
            e2 = it.r;
            e2.retired = it.r.retired & 16'h0003;
            if (!it.chk_alu) begin
               it.r.alucont = a1.alucont;
               e2.alucont   = a2.alucont;
            end
            check(it.nm, a1, it.r);
            check({it.nm, "_w2"}, a2, e2);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, act=running exp=finished");
      $fatal(1, "timeout");
   end

   function automatic logic is_legal(logic [5:0] op);
      return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   function automatic logic [2:0] fn_alu(logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic rec_t base();
      rec_t r;
      r = '0;
      r.retired = 16'(exp_ret);
      return r;
   endfunction

   task automatic cyc(string nm, rec_t r, bit ca, logic mr, logic zr);
      item_t it;
      bus1.mem_ready = mr;
      bus1.zero      = zr;
      it.nm = nm; it.r = r; it.chk_alu = ca;
      q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_phase(int fs);
      rec_t r;
      r = base(); r.alusrcb = 2'b01; r.alucont = 3'b010;
      for (int i = 0; i < fs; i++) cyc("fetch_stall", r, 1, 1'b0, 1'($urandom));
      r.irwrite = 1'b1; r.pcen = 1'b1;
      cyc("fetch", r, 1, 1'b1, 1'($urandom));
   endtask

   task automatic reset_cycle();
      rec_t r;
      reset_n = 1'b0;
      exp_ret = 0;
      r = base(); r.alusrcb = 2'b01; r.alucont = 3'b010;
      cyc("in_reset", r, 1, 1'b1, 1'($urandom));
      reset_n = 1'b1;
   endtask

   task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic zr, int fs, int ms);
      rec_t r;
      bus1.op    = op;
      bus1.funct = fn;
      fetch_phase(fs);
      r = base(); r.alusrcb = 2'b11; r.alucont = 3'b010; r.illegal = !is_legal(op);
      cyc("decode", r, 1, 1'($urandom), 1'($urandom));
      if (!is_legal(op)) return;
      case (op)
         6'b100011, 6'b101011: begin
            r = base(); r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alucont = 3'b010;
            cyc("memadr", r, 1, 1'($urandom), 1'($urandom));
            r = base(); r.iord = 1'b1; r.memwrite = (op == 6'b101011);
            for (int i = 0; i < ms; i++) cyc("mem_stall", r, 0, 1'b0, 1'($urandom));
            cyc("mem_done", r, 0, 1'b1, 1'($urandom));
            if (op == 6'b100011) begin
               r = base(); r.memtoreg = 1'b1; r.regwrite = 1'b1;
               cyc("memwb", r, 0, 1'($urandom), 1'($urandom));
            end
         end
         6'b000000: begin
            r = base(); r.alusrca = 1'b1; r.alucont = fn_alu(fn);
            cyc("rtypeex", r, 1, 1'($urandom), 1'($urandom));
            r = base(); r.regdst = 1'b1; r.regwrite = 1'b1;
            cyc("rtypewb", r, 0, 1'($urandom), 1'($urandom));
         end
         6'b000100: begin
            r = base(); r.alusrca = 1'b1; r.alucont = 3'b110; r.pcsrc = 2'b01; r.pcen = zr;
            cyc("beqex", r, 1, 1'($urandom), zr);
         end
         6'b001000: begin
            r = base(); r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alucont = 3'b010;
            cyc("addiex", r, 1, 1'($urandom), 1'($urandom));
            r = base(); r.regwrite = 1'b1;
            cyc("addiwb", r, 0, 1'($urandom), 1'($urandom));
         end
         default: begin
            r = base(); r.pcsrc = 2'b10; r.pcen = 1'b1;
            cyc("jex", r, 0, 1'($urandom), 1'($urandom));
         end
      endcase
      exp_ret++;
   endtask

   initial begin
      logic [5:0] ops[6];
      logic [5:0] fns[5];
      logic [5:0] op, fn;
      rec_t r;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      reset_n = 1'b0;
      bus1.op = 6'b0; bus1.funct = 6'b0; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      reset_cycle();
      // R-type aborted by reset in its execute cycle
      bus1.op = 6'b000000; bus1.funct = 6'b101010;
      fetch_phase(0);
      r = base(); r.alusrcb = 2'b11; r.alucont = 3'b010;
      cyc("decode", r, 1, 1'b1, 1'b0);
      reset_cycle();
      run_instr(6'b100011, 6'd0, 1'b0, 0, 0);
      run_instr(6'b101011, 6'd0, 1'b0, 1, 3);
      run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
      run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
      run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
      run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
      run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
      run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) run_instr(6'b000010, 6'($urandom), 1'b0, 0, 0);
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom); while (is_legal(op));
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) reset_cycle();
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: act=%0d pending exp=0 pending", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
